mem_arbiter: RTL and testbench

- Sequencer/arbiter sharing the byte-addressed 32-bit memory between the instruction-fetch port (read-only) and the load/store data port (read/write).
- Drives the memory's read address, write address, write data and write enable.
- The memory samples its inputs on the falling clock edge, so the arbiter registers everything on the rising edge.
- A data write and a fetch read proceed in the same slot when their byte ranges are disjoint.

---
 rtl/mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-addressed 32-bit memory between
// instruction fetch (read) and load/store (read/write) ports.
module mem_arbiter #(
  parameter int unsigned MEM_BYTES    = 1372,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ack,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [31:0] mem_raddr,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_in,
  output logic        mem_memwr,
  input  logic [31:0] mem_out
);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  localparam int SW =
    (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIM  = SW'(STARVE_LIMIT);
  localparam logic [31:0]   LAST = 32'(MEM_BYTES - 4);

  state_t        state, state_nx;
  logic [SW-1:0] starve, starve_nx;

  logic        if_ok, d_ok, ovl;
  logic [31:0] diff_a, diff_b;
  logic        g_if, g_d;

  // slot bookkeeping carried from decision to capture
  logic        p_if, p_d, p_dld;
  logic        p_iferr, p_derr;

  // range/overlap checks
  always_comb begin
    if_ok  = (if_addr <= LAST);
    d_ok   = (d_addr <= LAST);
    diff_a = if_addr - d_addr;
    diff_b = d_addr - if_addr;
    ovl    = if_ok && d_ok &&
             ((diff_a < 32'd4) || (diff_b < 32'd4));
  end

  // next state, grant decision and starvation counter
  always_comb begin
    state_nx  = state;
    starve_nx = starve;
    g_if      = 1'b0;
    g_d       = 1'b0;
    unique case (state)
      IDLE: begin
        if (if_req || d_req) begin
          state_nx = ACCESS;
          unique case (1'b1)
            if_req && !d_req: g_if = 1'b1;
            d_req && !if_req: g_d = 1'b1;
            if_req && d_req && !d_we: begin
              if (starve == LIM) g_if = 1'b1;
              else               g_d  = 1'b1;
            end
            if_req && d_req && d_we: begin
              g_d  = 1'b1;
              g_if = !ovl;
            end
          endcase
          if (!if_req || g_if)   starve_nx = '0;
          else if (starve != LIM) starve_nx = starve + SW'(1);
        end
      end
      ACCESS: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // fsm state and starvation counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      starve <= '0;
    end else begin
      state  <= state_nx;
      starve <= starve_nx;
    end
  end

  // memory drive at decision, read capture one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      mem_memwr <= 1'b0;
      mem_raddr <= '0;
      mem_waddr <= '0;
      mem_in    <= '0;
      if_rvalid <= 1'b0;
      if_err    <= 1'b0;
      if_rdata  <= '0;
      d_rvalid  <= 1'b0;
      d_err     <= 1'b0;
      d_rdata   <= '0;
      p_if      <= 1'b0;
      p_d       <= 1'b0;
      p_dld     <= 1'b0;
      p_iferr   <= 1'b0;
      p_derr    <= 1'b0;
    end else begin
      if_ack    <= g_if;
      d_ack     <= g_d;
      mem_memwr <= g_d && d_we && d_ok;
      if (g_if)
        mem_raddr <= if_addr;
      else if (g_d && !d_we)
        mem_raddr <= d_addr;
      if (g_d && d_we) begin
        mem_waddr <= d_addr;
        mem_in    <= d_wdata;
      end
      p_if    <= g_if;
      p_d     <= g_d;
      p_dld   <= g_d && !d_we;
      p_iferr <= g_if && !if_ok;
      p_derr  <= g_d && !d_ok;
      if_rvalid <= p_if;
      if_err    <= p_if && p_iferr;
      if (p_if && !p_iferr)
        if_rdata <= mem_out;
      d_rvalid <= p_d;
      d_err    <= p_d && p_derr;
      if (p_dld && !p_derr)
        d_rdata <= mem_out;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed timing checks plus a response
// scoreboard against a shadow byte memory.
module tb_mem_arbiter;

  localparam int MEMB = 1372;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ack, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ack, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic [31:0] mem_raddr, mem_waddr, mem_in;
  logic        mem_memwr;
  logic [31:0] mem_out = '0;

  mem_arbiter #(
    .MEM_BYTES(MEMB),
    .STARVE_LIMIT(3)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr),
    .if_ack(if_ack), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata), .d_err(d_err),
    .mem_raddr(mem_raddr), .mem_waddr(mem_waddr),
    .mem_in(mem_in), .mem_memwr(mem_memwr),
    .mem_out(mem_out)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [7:0] mem [MEMB];
  logic [7:0] shadow [MEMB];
  int wr_cnt = 0;

  function automatic logic [31:0] rd_sh(input logic [31:0] a);
    int i;
    i = int'(a);
    return {shadow[i+3], shadow[i+2], shadow[i+1], shadow[i]};
  endfunction

  function automatic bit in_rng(input logic [31:0] a);
    return a <= 32'(MEMB - 4);
  endfunction

  // memory device: samples on the falling edge
  initial forever begin
    int ra, wa;
    @(negedge clk);
    ra = int'(mem_raddr);
    if (in_rng(mem_raddr))
      mem_out = {mem[ra+3], mem[ra+2], mem[ra+1], mem[ra]};
    else
      mem_out = '0;
    if (mem_memwr) begin
      wr_cnt++;
      if (in_rng(mem_waddr)) begin
        wa = int'(mem_waddr);
        mem[wa]   = mem_in[7:0];
        mem[wa+1] = mem_in[15:8];
        mem[wa+2] = mem_in[23:16];
        mem[wa+3] = mem_in[31:24];
      end
    end
  end

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t q_if[$];
  exp_t q_d[$];
  logic [31:0] last_if = '0;
  logic [31:0] last_d = '0;

  // scoreboard: push at ack, compare at rvalid
  initial forever begin
    exp_t e;
    int   wa;
    @(negedge clk);
    if (rst_n) begin
      if (d_ack) begin
        if (d_we && in_rng(d_addr)) begin
          wa = int'(d_addr);
          shadow[wa]   = d_wdata[7:0];
          shadow[wa+1] = d_wdata[15:8];
          shadow[wa+2] = d_wdata[23:16];
          shadow[wa+3] = d_wdata[31:24];
        end
        if (!d_we && in_rng(d_addr))
          last_d = rd_sh(d_addr);
        q_d.push_back({last_d, !in_rng(d_addr)});
      end
      if (if_ack) begin
        if (in_rng(if_addr))
          last_if = rd_sh(if_addr);
        q_if.push_back({last_if, !in_rng(if_addr)});
      end
      if (if_rvalid) begin
        if (q_if.size() == 0) check("if_spurious", 1, 0);
        else begin
          e = q_if.pop_front();
          check("sb_if_rdata", if_rdata, e.data);
          check("sb_if_err", 32'(if_err), 32'(e.err));
        end
      end
      if (d_rvalid) begin
        if (q_d.size() == 0) check("d_spurious", 1, 0);
        else begin
          e = q_d.pop_front();
          check("sb_d_rdata", d_rdata, e.data);
          check("sb_d_err", 32'(d_err), 32'(e.err));
        end
      end
    end
  end

  task automatic fetch(input logic [31:0] a);
    bit got;
    got = 1'b0;
    if_addr = a;
    if_req = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = if_ack;
    end
    if (!got) check("if_ack_timeout", 0, 1);
    if_req = 1'b0;
  endtask

  task automatic dreq(input logic we,
                      input logic [31:0] a,
                      input logic [31:0] wd);
    bit got;
    got = 1'b0;
    d_we = we;
    d_addr = a;
    d_wdata = wd;
    d_req = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = d_ack;
    end
    if (!got) check("d_ack_timeout", 0, 1);
    d_req = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctl"},
          32'({if_ack, if_rvalid, if_err, d_ack,
               d_rvalid, d_err, mem_memwr}), 0);
    check({tag, "_if_rdata"}, if_rdata, 0);
    check({tag, "_d_rdata"}, d_rdata, 0);
    check({tag, "_raddr"}, mem_raddr, 0);
    check({tag, "_waddr"}, mem_waddr, 0);
    check({tag, "_mem_in"}, mem_in, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [9:0]  seq;
    int          ng;
    int          w0;
    logic [7:0]  b0;

    for (int i = 0; i < MEMB; i++) begin
      mem[i] = 8'($urandom);
      shadow[i] = mem[i];
    end
    mem[16] = 8'h11; mem[17] = 8'h22;
    mem[18] = 8'h33; mem[19] = 8'h44;
    for (int i = 16; i < 20; i++) shadow[i] = mem[i];

    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    // fetch of preloaded word, exact timing
    if_addr = 32'h10;
    if_req = 1'b1;
    @(negedge clk);
    check("t1_ack", 32'(if_ack), 1);
    if_req = 1'b0;
    @(negedge clk);
    check("t1_rvalid", 32'(if_rvalid), 1);
    check("t1_rdata", if_rdata, 32'h44332211);
    check("t1_err", 32'(if_err), 0);

    // disjoint store + fetch share a slot
    d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hDEADBEEF;
    d_req = 1'b1;
    if_addr = 32'h40; if_req = 1'b1;
    @(negedge clk);
    check("t2_acks", 32'({if_ack, d_ack}), 32'b11);
    check("t2_memwr", 32'(mem_memwr), 1);
    check("t2_waddr", mem_waddr, 32'h20);
    check("t2_mem_in", mem_in, 32'hDEADBEEF);
    d_req = 1'b0; if_req = 1'b0;
    @(negedge clk);
    check("t2_memwr_off", 32'(mem_memwr), 0);
    check("t2_drvalid", 32'(d_rvalid), 1);
    dreq(1'b0, 32'h20, 32'h0);
    @(negedge clk);
    check("t2_load", d_rdata, 32'hDEADBEEF);

    // overlapping store + fetch: fetch deferred one slot
    d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hCAFEF00D;
    d_req = 1'b1;
    if_addr = 32'h22; if_req = 1'b1;
    @(negedge clk);
    check("t3_acks", 32'({if_ack, d_ack}), 32'b01);
    d_req = 1'b0;
    @(negedge clk);
    check("t3_noack", 32'(if_ack), 0);
    @(negedge clk);
    check("t3_late_ack", 32'(if_ack), 1);
    if_req = 1'b0;
    @(negedge clk);
    check("t3_rvalid", 32'(if_rvalid), 1);
    check("t3_b0", 32'(if_rdata[7:0]), 32'hFE);
    check("t3_b1", 32'(if_rdata[15:8]), 32'hCA);

    // starvation: three data slots, forced fetch, data again
    d_we = 1'b0; d_addr = 32'h10; d_req = 1'b1;
    if_addr = 32'h40; if_req = 1'b1;
    seq = '0;
    ng = 0;
    for (int i = 0; i < 40 && ng < 5; i++) begin
      @(negedge clk);
      if (if_ack || d_ack) begin
        seq = {seq[7:0], if_ack, d_ack};
        ng++;
      end
    end
    d_req = 1'b0; if_req = 1'b0;
    check("t4_count", ng, 5);
    check("t4_seq", 32'(seq), 32'b01_01_01_10_01);
    repeat (2) @(negedge clk);

    // range boundary
    w0 = wr_cnt;
    dreq(1'b1, 32'd1369, 32'h11111111);
    @(negedge clk);
    check("t5_err_rv", 32'({d_rvalid, d_err}), 32'b11);
    check("t5_nowrite", wr_cnt, w0);
    dreq(1'b1, 32'd1368, 32'h12345678);
    @(negedge clk);
    check("t5_ok_rv", 32'({d_rvalid, d_err}), 32'b10);
    check("t5_write", wr_cnt, w0 + 1);
    fetch(32'hFFFFFFFC);
    @(negedge clk);
    check("t5_if_err", 32'({if_rvalid, if_err}), 32'b11);
    dreq(1'b0, 32'd1368, 32'h0);
    @(negedge clk);
    check("t5_load", d_rdata, 32'h12345678);

    // reset during the access cycle of a store
    w0 = wr_cnt;
    b0 = mem[48];
    d_we = 1'b1; d_addr = 32'h30; d_wdata = 32'h55AA55AA;
    d_req = 1'b1;
    @(posedge clk);
    #1;
    check("t6_memwr_on", 32'(mem_memwr), 1);
    rst_n = 1'b0;
    d_req = 1'b0;
    last_if = '0;
    last_d = '0;
    #1;
    check("t6_memwr_drop", 32'(mem_memwr), 0);
    @(negedge clk);
    check("t6_nowrite", wr_cnt, w0);
    check("t6_byte", 32'(mem[48]), 32'(b0));
    @(negedge clk);
    check("t6_norv", 32'({if_rvalid, d_rvalid}), 0);
    rst_n = 1'b1;
    check_zero("t6_after");
    dreq(1'b1, 32'h30, 32'h55AA55AA);
    @(negedge clk);
    dreq(1'b0, 32'h30, 32'h0);
    @(negedge clk);
    check("t6_reissue", d_rdata, 32'h55AA55AA);

    repeat (4) @(negedge clk);
    check("q_if_empty", q_if.size(), 0);
    check("q_d_empty", q_d.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
